// File: rtl/audio_i2s_engine.sv
// Master-mode I2S / left-justified / TDM serial engine: MCLK, BCLK and LRCK generation plus DAC/ADC shifting.
// Optional AUDIO_GPIO_PROBE_EN adds an 8-bit registered probe port for the expansion header.
module audio_i2s_engine #(
  parameter int unsigned MCLK_DIV = 2,
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned LJ_FMT   = 0
) (
  input  logic                         clk,
  input  logic                         swt,
  input  logic                         en,
  output logic                         aud_xclk,
  output logic                         bclk,
  output logic                         lrck,
  output logic                         dacdat,
  input  logic                         adcdat,
  input  logic [CHANNELS*SAMPLE_W-1:0] tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] rx_data,
  output logic                         rx_valid,
  output logic                         underrun
`ifdef AUDIO_GPIO_PROBE_EN
  ,
  output logic [7:0]                   gpio
`endif
);

  localparam int unsigned DW  = CHANNELS * SAMPLE_W;
  localparam int unsigned IW  = $clog2(DW);
  localparam int unsigned MCW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int unsigned BCW = $clog2(BCLK_DIV);
  localparam int unsigned SLW = $clog2(CHANNELS);
  localparam int unsigned SBW = $clog2(SLOT_W);
  localparam int          OFF = (LJ_FMT != 0) ? 0 : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [MCW-1:0]   mcnt;
  logic [BCW-1:0]   bcnt;
  logic [SLW-1:0]   slot;
  logic [SBW-1:0]   sbit;
  logic [DW-1:0]    hold;
  logic [DW-1:0]    tx_sh;
  logic [DW-1:0]    rx_acc;

  logic             rise_c, fall_c, wrap_c, start_c, dac_c, lrck_c;
  logic [SLW-1:0]   nslot, pslot;
  logic [SBW-1:0]   nsbit, psbit;
  logic [DW-1:0]    frame_c, rx_c;

  // True when a slot bit position carries sample data rather than padding.
  function automatic logic hit(input logic [SBW-1:0] sb);
    return (int'(sb) >= OFF) && ((int'(sb) - OFF) < int'(SAMPLE_W));
  endfunction

  // Packed-bus index of the sample bit carried at (slot, slot bit), MSB first.
  function automatic logic [IW-1:0] pos(input logic [SLW-1:0] sl, input logic [SBW-1:0] sb);
    return IW'(int'(sl) * int'(SAMPLE_W) + int'(SAMPLE_W) - 1 - int'(sb) + OFF);
  endfunction

  always_comb begin
    rise_c  = (bcnt == BCW'(BCLK_DIV - 1)) && !bclk;
    fall_c  = (bcnt == BCW'(BCLK_DIV - 1)) && bclk;
    wrap_c  = (sbit == SBW'(SLOT_W - 1)) && (slot == SLW'(CHANNELS - 1));
    nslot   = slot;
    nsbit   = sbit + SBW'(1);
    if (sbit == SBW'(SLOT_W - 1)) begin
      nsbit = '0;
      nslot = (slot == SLW'(CHANNELS - 1)) ? '0 : slot + SLW'(1);
    end
    start_c = en && ((state == IDLE) || (fall_c && wrap_c));
    pslot   = (state == IDLE) ? '0 : nslot;
    psbit   = (state == IDLE) ? '0 : nsbit;
    // An empty holding register at frame start sends an all-zero frame.
    frame_c = start_c ? (tx_ready ? '0 : hold) : tx_sh;
    dac_c   = hit(psbit) ? frame_c[pos(pslot, psbit)] : 1'b0;
    if (CHANNELS == 2) lrck_c = pslot[0];
    else               lrck_c = (pslot == '0) && (psbit == '0);
    rx_c = rx_acc;
    if (hit(sbit)) rx_c[pos(slot, sbit)] = adcdat;
  end

  always_ff @(posedge clk) begin
    if (!swt) begin
      state    <= IDLE;
      mcnt     <= '0;
      bcnt     <= '0;
      slot     <= '0;
      sbit     <= '0;
      aud_xclk <= 1'b0;
      bclk     <= 1'b0;
      lrck     <= 1'b0;
      dacdat   <= 1'b0;
      hold     <= '0;
      tx_sh    <= '0;
      rx_acc   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b1;
      underrun <= 1'b0;
    end else begin
      if (mcnt == MCW'(MCLK_DIV - 1)) begin
        mcnt     <= '0;
        aud_xclk <= ~aud_xclk;
      end else begin
        mcnt <= mcnt + MCW'(1);
      end

      rx_valid <= 1'b0;
      if (start_c) begin
        tx_sh    <= frame_c;
        tx_ready <= 1'b1;
        if (tx_ready) underrun <= 1'b1;
      end
      // A load coinciding with frame start is kept for the following frame.
      if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      if (!en) begin
        state  <= IDLE;
        bcnt   <= '0;
        slot   <= '0;
        sbit   <= '0;
        bclk   <= 1'b0;
        lrck   <= 1'b0;
        dacdat <= 1'b0;
      end else if (state == IDLE) begin
        state  <= RUN;
        bcnt   <= '0;
        slot   <= '0;
        sbit   <= '0;
        bclk   <= 1'b0;
        lrck   <= lrck_c;
        dacdat <= dac_c;
      end else begin
        if (bcnt == BCW'(BCLK_DIV - 1)) begin
          bcnt <= '0;
          bclk <= ~bclk;
        end else begin
          bcnt <= bcnt + BCW'(1);
        end
        if (rise_c) begin
          rx_acc <= rx_c;
          if (wrap_c) begin
            rx_data  <= rx_c;
            rx_valid <= 1'b1;
          end
        end
        if (fall_c) begin
          slot   <= nslot;
          sbit   <= nsbit;
          lrck   <= lrck_c;
          dacdat <= dac_c;
        end
      end
    end
  end

`ifdef AUDIO_GPIO_PROBE_EN
  // Probe snapshot, one clk behind the pins it mirrors.
  always_ff @(posedge clk) begin
    if (!swt) gpio <= '0;
    else      gpio <= {underrun, start_c, rx_valid, adcdat, lrck, dacdat, bclk, aud_xclk};
  end
`endif

endmodule
